// File: rtl/dlx_mem_pkg.sv
// dlx_mem_pkg: shared encodings and helpers for the DLX unified-memory port.
//   memSize_e   : access size encoding (byte / half / word / illegal)
//   arbState_e  : arbiter FSM states
//   reqId_e     : requester identifiers (instruction fetch / data memory)
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE    = 2'b00,
        SZ_HALF    = 2'b01,
        SZ_WORD    = 2'b10,
        SZ_ILLEGAL = 2'b11
    } memSize_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        ACK  = 2'b11
    } arbState_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } reqId_e;

    // Number of bytes moved by an access; 0 for the illegal encoding.
    function automatic logic [2:0] sizeBytes(input memSize_e size);
        case (size)
            SZ_BYTE: return 3'd1;
            SZ_HALF: return 3'd2;
            SZ_WORD: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    // Natural-alignment check on the two address LSBs.
    function automatic logic sizeMisaligned(input memSize_e size, input logic [1:0] addrLsb);
        case (size)
            SZ_HALF: return addrLsb[0];
            SZ_WORD: return (addrLsb != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Byte idx of a right-justified store, most-significant byte of the size first.
    function automatic logic [7:0] storeByte(input logic [31:0] data, input memSize_e size,
                                             input logic [2:0] idx);
        logic [1:0] lane;
        lane = 2'(sizeBytes(size) - 3'd1 - idx);
        return data[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: combinational two-way round-robin choice between IF and DM.
//   IfReq, DmReq : pending requests
//   LastGrant    : requester served most recently
//   grant_valid  : at least one request is pending
//   grant_id     : requester to serve; on conflict, the one not served last
module mem_rr_pick
    import dlx_mem_pkg::*;
(
    input  logic   IfReq,
    input  logic   DmReq,
    input  reqId_e LastGrant,
    output logic   grant_valid,
    output reqId_e grant_id
);

    always_comb begin
        grant_valid = IfReq | DmReq;
        grant_id    = REQ_IF;
        if (IfReq && DmReq) begin
            grant_id = (LastGrant == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (DmReq) begin
            grant_id = REQ_DM;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the byte-wide big-endian DLX memory between the
// instruction-fetch and data-memory requesters.
//   Clock, Reset_n             : clock, async active-low reset
//   IfReq/IfAddr               : fetch request (always an aligned word read)
//   IfAck/IfData/IfErr         : fetch completion pulse, registered word, error
//   DmReq/DmWrite/DmSize/DmAddr/DmWrData : data request
//   DmAck/DmRdData/DmErr       : data completion pulse, zero-extended load, error
//   Busy                       : FSM not in IDLE
//   MemAddress/MemWriteData/MemRead/MemWrite : memory side (one byte per write)
//   MemData                    : combinational big-endian word from memory
module mem_port_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024,
    parameter int unsigned ADDR_W    = 32
)
(
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic              IfAck,
    output logic [31:0]       IfData,
    output logic              IfErr,
    input  logic              DmReq,
    input  logic              DmWrite,
    input  logic [1:0]        DmSize,
    input  logic [ADDR_W-1:0] DmAddr,
    input  logic [31:0]       DmWrData,
    output logic              DmAck,
    output logic [31:0]       DmRdData,
    output logic              DmErr,
    output logic              Busy,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [31:0]       MemWriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [31:0]       MemData
);

    // One extra bit so addr + nbytes cannot wrap in the range check.
    localparam int unsigned EXT_W = ADDR_W + 1;

    arbState_e         state, nextState;
    reqId_e            lastGrant, lastGrantNext;
    reqId_e            reqId, reqIdNext;
    memSize_e          size, sizeNext;
    logic [ADDR_W-1:0] addr, addrNext;
    logic [31:0]       wrData, wrDataNext;
    logic              err, errNext;
    logic [2:0]        count, countNext;

    logic              ifAckNext, ifErrNext, dmAckNext, dmErrNext, busyNext;
    logic              memReadNext, memWriteNext;
    logic [31:0]       ifDataNext, dmRdDataNext, memWriteDataNext;
    logic [ADDR_W-1:0] memAddressNext;

    logic              grantValid;
    reqId_e            grantId;
    logic [ADDR_W-1:0] selAddr;
    memSize_e          selSize;
    logic              selWrite;
    logic [2:0]        selBytes;
    logic              selErr;
    logic [2:0]        countInc;
    logic              lastByte;

    mem_rr_pick uPick (
        .IfReq       (IfReq),
        .DmReq       (DmReq),
        .LastGrant   (lastGrant),
        .grant_valid (grantValid),
        .grant_id    (grantId)
    );

    // Request selected by the arbiter and its legality.
    assign selAddr  = (grantId == REQ_DM) ? DmAddr : IfAddr;
    assign selSize  = (grantId == REQ_DM) ? memSize_e'(DmSize) : SZ_WORD;
    assign selWrite = (grantId == REQ_DM) & DmWrite;
    assign selBytes = sizeBytes(selSize);
    assign selErr   = (selSize == SZ_ILLEGAL)
                    | sizeMisaligned(selSize, selAddr[1:0])
                    | (({1'b0, selAddr} + EXT_W'(selBytes)) > EXT_W'(MEM_BYTES));

    assign countInc = 3'(count + 3'd1);
    assign lastByte = (count == 3'(sizeBytes(size) - 3'd1));

    // Next-state and registered-output logic.
    always_comb begin
        nextState        = state;
        lastGrantNext    = lastGrant;
        reqIdNext        = reqId;
        sizeNext         = size;
        addrNext         = addr;
        wrDataNext       = wrData;
        errNext          = err;
        countNext        = count;
        ifAckNext        = 1'b0;
        ifErrNext        = 1'b0;
        dmAckNext        = 1'b0;
        dmErrNext        = 1'b0;
        memReadNext      = 1'b0;
        memWriteNext     = 1'b0;
        ifDataNext       = IfData;
        dmRdDataNext     = DmRdData;
        memAddressNext   = MemAddress;
        memWriteDataNext = MemWriteData;

        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    lastGrantNext = grantId;
                    reqIdNext     = grantId;
                    sizeNext      = selSize;
                    addrNext      = selAddr;
                    wrDataNext    = DmWrData;
                    errNext       = selErr;
                    countNext     = 3'd0;
                    if (selErr) begin
                        // No memory cycle: acknowledge with the error flag directly.
                        nextState = ACK;
                        ifAckNext = (grantId == REQ_IF);
                        ifErrNext = (grantId == REQ_IF);
                        dmAckNext = (grantId == REQ_DM);
                        dmErrNext = (grantId == REQ_DM);
                    end else if (!selWrite) begin
                        nextState      = RD;
                        memReadNext    = 1'b1;
                        memAddressNext = selAddr;
                    end else begin
                        nextState        = WR;
                        memWriteNext     = 1'b1;
                        memAddressNext   = selAddr;
                        memWriteDataNext = {24'b0, storeByte(DmWrData, selSize, 3'd0)};
                    end
                end
            end

            RD: begin
                // MemData reflects the address driven during this cycle.
                if (reqId == REQ_IF) begin
                    ifDataNext = MemData;
                end else begin
                    case (size)
                        SZ_BYTE: dmRdDataNext = {24'b0, MemData[31:24]};
                        SZ_HALF: dmRdDataNext = {16'b0, MemData[31:16]};
                        default: dmRdDataNext = MemData;
                    endcase
                end
                nextState = ACK;
                ifAckNext = (reqId == REQ_IF);
                ifErrNext = (reqId == REQ_IF) & err;
                dmAckNext = (reqId == REQ_DM);
                dmErrNext = (reqId == REQ_DM) & err;
            end

            WR: begin
                if (lastByte) begin
                    nextState = ACK;
                    ifAckNext = (reqId == REQ_IF);
                    ifErrNext = (reqId == REQ_IF) & err;
                    dmAckNext = (reqId == REQ_DM);
                    dmErrNext = (reqId == REQ_DM) & err;
                end else begin
                    countNext        = countInc;
                    memWriteNext     = 1'b1;
                    memAddressNext   = addr + ADDR_W'(countInc);
                    memWriteDataNext = {24'b0, storeByte(wrData, size, countInc)};
                end
            end

            ACK: begin
                nextState = IDLE;
            end

            default: begin
                nextState = IDLE;
            end
        endcase

        busyNext = (nextState != IDLE);
    end

    // State and output registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            lastGrant    <= REQ_IF;
            reqId        <= REQ_IF;
            size         <= SZ_BYTE;
            addr         <= '0;
            wrData       <= '0;
            err          <= 1'b0;
            count        <= 3'd0;
            IfAck        <= 1'b0;
            IfErr        <= 1'b0;
            IfData       <= '0;
            DmAck        <= 1'b0;
            DmErr        <= 1'b0;
            DmRdData     <= '0;
            Busy         <= 1'b0;
            MemRead      <= 1'b0;
            MemWrite     <= 1'b0;
            MemAddress   <= '0;
            MemWriteData <= '0;
        end else begin
            state        <= nextState;
            lastGrant    <= lastGrantNext;
            reqId        <= reqIdNext;
            size         <= sizeNext;
            addr         <= addrNext;
            wrData       <= wrDataNext;
            err          <= errNext;
            count        <= countNext;
            IfAck        <= ifAckNext;
            IfErr        <= ifErrNext;
            IfData       <= ifDataNext;
            DmAck        <= dmAckNext;
            DmErr        <= dmErrNext;
            DmRdData     <= dmRdDataNext;
            Busy         <= busyNext;
            MemRead      <= memReadNext;
            MemWrite     <= memWriteNext;
            MemAddress   <= memAddressNext;
            MemWriteData <= memWriteDataNext;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a byte-wide
// big-endian memory model.
module tb_mem_port_arbiter;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int unsigned ADDR_W    = 32;

    logic              Clock;
    logic              Reset_n;
    logic              IfReq;
    logic [ADDR_W-1:0] IfAddr;
    logic              IfAck;
    logic [31:0]       IfData;
    logic              IfErr;
    logic              DmReq;
    logic              DmWrite;
    logic [1:0]        DmSize;
    logic [ADDR_W-1:0] DmAddr;
    logic [31:0]       DmWrData;
    logic              DmAck;
    logic [31:0]       DmRdData;
    logic              DmErr;
    logic              Busy;
    logic [ADDR_W-1:0] MemAddress;
    logic [31:0]       MemWriteData;
    logic              MemRead;
    logic              MemWrite;
    logic [31:0]       MemData;

    mem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .IfReq        (IfReq),
        .IfAddr       (IfAddr),
        .IfAck        (IfAck),
        .IfData       (IfData),
        .IfErr        (IfErr),
        .DmReq        (DmReq),
        .DmWrite      (DmWrite),
        .DmSize       (DmSize),
        .DmAddr       (DmAddr),
        .DmWrData     (DmWrData),
        .DmAck        (DmAck),
        .DmRdData     (DmRdData),
        .DmErr        (DmErr),
        .Busy         (Busy),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemData      (MemData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory model: combinational big-endian read, one byte written per clock.
    logic [7:0] mem    [0:MEM_BYTES-1];
    logic [7:0] refMem [0:MEM_BYTES-1];
    logic       bdWe;
    logic [9:0] bdAddr;
    logic [7:0] bdData;

    always_comb begin
        logic [31:0] ad;
        MemData = '0;
        for (int k = 0; k < 4; k++) begin
            ad = MemAddress + 32'(k);
            MemData[31-8*k -: 8] = (ad < MEM_BYTES) ? mem[ad[9:0]] : 8'h00;
        end
    end

    always @(posedge Clock) begin
        if (bdWe) mem[bdAddr] <= bdData;
        else if (MemWrite && (MemAddress < MEM_BYTES)) mem[MemAddress[9:0]] <= MemWriteData[7:0];
    end

    typedef struct packed { logic [31:0] addr; logic [7:0] data; } wrExp_t;
    typedef struct packed { logic [31:0] data; logic err; } ackExp_t;

    wrExp_t  wrExpQ[$];
    ackExp_t ifExpQ[$];
    ackExp_t dmExpQ[$];
    logic    ackLog[$];

    int          numChecks = 0;
    int          numErrors = 0;
    int          rdCycles  = 0;
    int          wrCycles  = 0;
    logic [31:0] expIfData = '0;
    logic [31:0] expDmRd   = '0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numChecks++;
        if (got !== exp) begin
            numErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] initVal(input int a);
        logic [31:0] w;
        w = 32'h02124804;
        if (a < 4) return w[31-8*a -: 8];
        if ((a < 12) || (a >= 'h200 && a < 'h20C)) return 8'(a * 37 + 5);
        return 8'h00;
    endfunction

    // Output monitor: scoreboard pops on writes and acks.
    always @(posedge Clock) begin
        wrExp_t  w;
        ackExp_t x;
        #1;
        if (MemRead) rdCycles++;
        if (MemRead && MemWrite) checkVal("rd_wr_overlap", 32'd1, 32'd0);
        if (MemWrite) begin
            wrCycles++;
            if (wrExpQ.size() == 0) checkVal("wr_unexpected", 32'd1, 32'd0);
            else begin
                w = wrExpQ.pop_front();
                checkVal("wr_addr", MemAddress, w.addr);
                checkVal("wr_data", MemWriteData, {24'b0, w.data});
            end
        end
        if (IfAck && DmAck) checkVal("dual_ack", 32'd1, 32'd0);
        if (IfAck) begin
            ackLog.push_back(1'b0);
            if (ifExpQ.size() == 0) checkVal("if_ack_unexpected", 32'd1, 32'd0);
            else begin
                x = ifExpQ.pop_front();
                checkVal("if_data", IfData, x.data);
                checkVal("if_err", 32'(IfErr), 32'(x.err));
            end
        end
        if (DmAck) begin
            ackLog.push_back(1'b1);
            if (dmExpQ.size() == 0) checkVal("dm_ack_unexpected", 32'd1, 32'd0);
            else begin
                x = dmExpQ.pop_front();
                checkVal("dm_rddata", DmRdData, x.data);
                checkVal("dm_err", 32'(DmErr), 32'(x.err));
            end
        end
    end

    task automatic waitAck(input bit dm, input string tag, output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < 60) begin
            @(posedge Clock); #1;
            lat++;
            if (dm ? DmAck : IfAck) ok = 1'b1;
        end
        if (!ok) checkVal({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // Push the expected result of a fetch; returns its error flag.
    function automatic logic pushIf(input logic [31:0] addr);
        logic err;
        err = (addr[1:0] != 2'b00) || ((64'(addr) + 64'd4) > 64'(MEM_BYTES));
        if (!err) expIfData = {refMem[addr], refMem[addr+1], refMem[addr+2], refMem[addr+3]};
        ifExpQ.push_back('{expIfData, err});
        return err;
    endfunction

    // Push the expected results of a data access; returns nbytes, 0 on error.
    function automatic int pushDm(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                                  input logic [31:0] wdata);
        int          nb;
        logic        err;
        logic [7:0]  b;
        logic [31:0] rdata;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : (sz == 2'b10) ? 4 : 0;
        err = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00)
            || ((64'(addr) + 64'(nb)) > 64'(MEM_BYTES));
        if (!err) begin
            if (wr) begin
                for (int i = 0; i < nb; i++) begin
                    b = 8'(wdata >> (8 * (nb - 1 - i)));
                    wrExpQ.push_back('{addr + 32'(i), b});
                    refMem[int'(addr) + i] = b;
                end
            end else begin
                rdata = '0;
                for (int i = 0; i < nb; i++) rdata = {rdata[23:0], refMem[int'(addr) + i]};
                expDmRd = rdata;
            end
        end
        dmExpQ.push_back('{expDmRd, err});
        return err ? 0 : nb;
    endfunction

    task automatic ifFetch(input string tag, input logic [31:0] addr);
        logic err;
        bit   ok;
        int   lat, rd0;
        err = pushIf(addr);
        rd0 = rdCycles;
        @(negedge Clock);
        IfReq  = 1'b1;
        IfAddr = addr;
        waitAck(1'b0, tag, ok, lat);
        if (ok) checkVal({tag, "_lat"}, 32'(lat), err ? 32'd1 : 32'd2);
        @(posedge Clock); #1;
        IfReq = 1'b0;
        checkVal({tag, "_rd_cycles"}, 32'(rdCycles - rd0), err ? 32'd0 : 32'd1);
    endtask

    task automatic dmAccess(input string tag, input logic wr, input logic [1:0] sz,
                            input logic [31:0] addr, input logic [31:0] wdata);
        int nb, lat, rd0, wr0;
        bit ok;
        nb  = pushDm(wr, sz, addr, wdata);
        rd0 = rdCycles;
        wr0 = wrCycles;
        @(negedge Clock);
        DmReq    = 1'b1;
        DmWrite  = wr;
        DmSize   = sz;
        DmAddr   = addr;
        DmWrData = wdata;
        waitAck(1'b1, tag, ok, lat);
        if (ok) checkVal({tag, "_lat"}, 32'(lat), (nb == 0) ? 32'd1 : (wr ? 32'(nb + 1) : 32'd2));
        @(posedge Clock); #1;
        DmReq = 1'b0;
        checkVal({tag, "_rd_cycles"}, 32'(rdCycles - rd0), (nb != 0 && !wr) ? 32'd1 : 32'd0);
        checkVal({tag, "_wr_cycles"}, 32'(wrCycles - wr0), wr ? 32'(nb) : 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        int lat;
        Reset_n  = 1'b0;
        IfReq    = 1'b0;
        IfAddr   = '0;
        DmReq    = 1'b0;
        DmWrite  = 1'b0;
        DmSize   = 2'b00;
        DmAddr   = '0;
        DmWrData = '0;
        bdWe     = 1'b0;
        bdAddr   = '0;
        bdData   = '0;

        // Preload memory while the DUT is held in reset.
        for (int a = 0; a < int'(MEM_BYTES); a++) begin
            @(negedge Clock);
            bdWe      = 1'b1;
            bdAddr    = 10'(a);
            bdData    = initVal(a);
            refMem[a] = initVal(a);
        end
        @(negedge Clock);
        bdWe = 1'b0;

        checkVal("rst_if_ack",    32'(IfAck), 32'd0);
        checkVal("rst_if_err",    32'(IfErr), 32'd0);
        checkVal("rst_if_data",   IfData, 32'd0);
        checkVal("rst_dm_ack",    32'(DmAck), 32'd0);
        checkVal("rst_dm_err",    32'(DmErr), 32'd0);
        checkVal("rst_dm_data",   DmRdData, 32'd0);
        checkVal("rst_busy",      32'(Busy), 32'd0);
        checkVal("rst_mem_read",  32'(MemRead), 32'd0);
        checkVal("rst_mem_write", 32'(MemWrite), 32'd0);
        checkVal("rst_mem_addr",  MemAddress, 32'd0);
        checkVal("rst_mem_wdata", MemWriteData, 32'd0);

        @(negedge Clock);
        Reset_n = 1'b1;
        @(negedge Clock);

        // Conflict right after reset: DM first, then strict alternation.
        ackLog.delete();
        for (int k = 0; k < 3; k++) begin
            void'(pushDm(1'b0, 2'b10, 32'h200 + 32'(4 * k), 32'd0));
            void'(pushIf(32'(4 * k)));
        end
        fork
            begin
                bit okD;
                int latD;
                @(negedge Clock);
                DmReq = 1'b1; DmWrite = 1'b0; DmSize = 2'b10; DmAddr = 32'h200;
                for (int k = 0; k < 3; k++) begin
                    waitAck(1'b1, "conflict_dm", okD, latD);
                    @(posedge Clock); #1;
                    if (k < 2) DmAddr = 32'h200 + 32'(4 * (k + 1));
                    else DmReq = 1'b0;
                end
            end
            begin
                bit okI;
                int latI;
                @(negedge Clock);
                IfReq = 1'b1; IfAddr = 32'h0;
                for (int k = 0; k < 3; k++) begin
                    waitAck(1'b0, "conflict_if", okI, latI);
                    @(posedge Clock); #1;
                    if (k < 2) IfAddr = 32'(4 * (k + 1));
                    else IfReq = 1'b0;
                end
            end
        join
        checkVal("order_len", 32'(ackLog.size()), 32'd6);
        for (int k = 0; k < 6 && k < ackLog.size(); k++)
            checkVal($sformatf("order_%0d", k), 32'(ackLog[k]), 32'((k % 2) == 0));

        ifFetch("fetch0", 32'h0);
        dmAccess("st_word", 1'b1, 2'b10, 32'h100, 32'hA1B2C3D4);
        dmAccess("ld_word", 1'b0, 2'b10, 32'h100, 32'd0);
        dmAccess("ld_half", 1'b0, 2'b01, 32'h102, 32'd0);
        dmAccess("ld_byte", 1'b0, 2'b00, 32'h101, 32'd0);
        dmAccess("st_half", 1'b1, 2'b01, 32'h10A, 32'hFFFF5A6B);
        dmAccess("ld_half2", 1'b0, 2'b01, 32'h10A, 32'd0);

        dmAccess("err_half", 1'b0, 2'b01, 32'h101, 32'd0);
        dmAccess("err_word", 1'b1, 2'b10, 32'h3FE, 32'hDEADBEEF);
        dmAccess("err_size", 1'b0, 2'b11, 32'h10, 32'd0);
        dmAccess("err_range", 1'b0, 2'b10, 32'h400, 32'd0);
        ifFetch("if_misaligned", 32'h2);

        dmAccess("st_top", 1'b1, 2'b00, 32'h3FF, 32'h12345678);
        dmAccess("ld_top", 1'b0, 2'b00, 32'h3FF, 32'd0);

        // Reset during the second byte of a word store.
        wrExpQ.push_back('{32'h300, 8'h11});
        wrExpQ.push_back('{32'h301, 8'h22});
        @(negedge Clock);
        DmReq = 1'b1; DmWrite = 1'b1; DmSize = 2'b10; DmAddr = 32'h300; DmWrData = 32'h11223344;
        ok  = 1'b0;
        lat = 0;
        while (!ok && lat < 20) begin
            @(posedge Clock); #1;
            lat++;
            if (MemWrite && MemAddress == 32'h301) ok = 1'b1;
        end
        if (!ok) checkVal("midrst_wait_timeout", 32'd0, 32'd1);
        #2;
        Reset_n = 1'b0;
        DmReq   = 1'b0;
        #1;
        checkVal("midrst_mem_write", 32'(MemWrite), 32'd0);
        checkVal("midrst_busy", 32'(Busy), 32'd0);
        checkVal("midrst_dm_ack", 32'(DmAck), 32'd0);
        wrExpQ.delete();
        checkVal("midrst_byte0", 32'(mem[10'h300]), 32'h11);
        checkVal("midrst_byte1", 32'(mem[10'h301]), 32'h00);
        refMem['h300] = 8'h11;
        expDmRd   = '0;
        expIfData = '0;
        repeat (2) @(negedge Clock);
        Reset_n = 1'b1;
        repeat (2) @(negedge Clock);
        checkVal("midrst_idle_busy", 32'(Busy), 32'd0);
        dmAccess("ld_after_rst", 1'b0, 2'b10, 32'h300, 32'd0);

        repeat (3) @(negedge Clock);
        checkVal("left_if_exp", 32'(ifExpQ.size()), 32'd0);
        checkVal("left_dm_exp", 32'(dmExpQ.size()), 32'd0);
        checkVal("left_wr_exp", 32'(wrExpQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressed, big-endian unified memory between the instruction-fetch (IF) and data-memory (DM) requesters of the multi-cycle DLX.
- Round-robin arbitration between the two requesters, with a Req/Ack handshake on each side.
- Splits half-word and word stores into sequential single-byte memory writes, because the memory writes only one byte per clock.
- Sits between the control/datapath and the memory; registers read data and flags misaligned or out-of-range accesses.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- ADDR_W, 32, width of every address port.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset_n  in  1  reset, asynchronous, active-low.
- IfReq  in  1  fetch request; held high until IfAck.
- IfAddr  in  ADDR_W  fetch byte address (word access).
- IfAck  out  1  one-cycle completion pulse for the fetch.
- IfData  out  32  registered fetched word.
- IfErr  out  1  valid with IfAck; access was misaligned or out of range.
- DmReq  in  1  data request; held high until DmAck.
- DmWrite  in  1  1 = store, 0 = load.
- DmSize  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- DmAddr  in  ADDR_W  data byte address.
- DmWrData  in  32  store data, right-justified.
- DmAck  out  1  one-cycle completion pulse for the data access.
- DmRdData  out  32  registered load data, zero-extended.
- DmErr  out  1  valid with DmAck.
- Busy  out  1  high in any state other than IDLE.
- MemAddress  out  ADDR_W  memory address.
- MemWriteData  out  32  {24'b0, byte}.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- MemData  in  32  combinational big-endian word from the memory.

Behaviour:
- Reset: state = IDLE, byte count = 0, LastGrant = IF. All outputs are 0: Acks, Errs, IfData, DmRdData, MemRead, MemWrite, MemAddress, MemWriteData.
- Reset mid-operation: clears immediately and asynchronously; MemWrite drops at once. Bytes already written stay written; the requester gets no Ack.
- States: IDLE, RD, WR, ACK.
- IDLE: sample IfReq and DmReq.
  - Both high: grant the requester that is not LastGrant, so DM wins the first conflict after reset.
  - Exactly one high: grant it.
  - On grant: latch requester id, address, write flag, size (IF is always a word read) and write data; update LastGrant.
  - Then: if error, go to ACK with Err set; else a read goes to RD, a write goes to WR with count = 0.
- Error conditions:
  - half access with addr[0] != 0;
  - word access with addr[1:0] != 0;
  - DmSize = 11;
  - addr + nbytes > MEM_BYTES.
  - On error there is no memory cycle, and the read data output is unchanged.
- RD (1 cycle): MemRead = 1, MemAddress = latched address.
  - At the cycle's end, capture the result.
  - IF: IfData = MemData.
  - DM word: MemData.
  - DM half: {16'b0, MemData[31:16]}.
  - DM byte: {24'b0, MemData[31:24]}.
  - Then go to ACK.
- WR (nbytes cycles, 1/2/4): MemWrite = 1, MemAddress = addr + count.
  - Byte order is big-endian: the most-significant byte of the size goes first.
  - Word: [31:24], [23:16], [15:8], [7:0].
  - Half: [15:8], [7:0].
  - Byte: [7:0].
  - count increments each cycle; on the last byte go to ACK.
- ACK (1 cycle): the granted requester's Ack = 1 and Err = latched error flag. The other requester's Ack stays 0. Then go to IDLE.
- Handshake: the requester drops Req on the clock edge that samples Ack = 1, so the IDLE that follows sees Req low. A Req that is still high in IDLE starts a new transaction.
- Latency, from the IDLE grant edge to Ack high:
  - read: 2 cycles;
  - write: nbytes + 1 cycles;
  - error: 1 cycle.
- MemRead and MemWrite are never high together and are 0 in IDLE and ACK. MemAddress holds its last value in IDLE.
- A request arriving during a transaction waits. Round-robin guarantees each requester is served within one foreign transaction.
- Address arithmetic is ADDR_W-wide; the range check runs before any access, so addr + count never wraps.

Decomposition:
- Shared package dlx_mem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
  - state encodings for IDLE, RD, WR, ACK;
  - requester ids REQ_IF, REQ_DM.
- One sub-module, mem_rr_pick: a combinational 2-way round-robin choice from IfReq, DmReq and LastGrant. It outputs grant_valid and grant_id.
- The FSM, byte sequencer and error check stay in mem_port_arbiter.

Test Plan:
- Fetch only: memory holds 0x02124804 at byte address 0; IfReq with IfAddr = 0. Expect MemRead high for exactly 1 cycle, then IfAck pulse with IfData = 0x02124804 and IfErr = 0, 2 cycles after grant.
- Word store: DM store, size 10, addr 0x100, data 0xA1B2C3D4. Expect 4 MemWrite cycles with (address, MemWriteData) = (0x100, 0xA1), (0x101, 0xB2), (0x102, 0xC3), (0x103, 0xD4), then DmAck. A following word load of 0x100 returns 0xA1B2C3D4; a half load of 0x102 returns 0x0000C3D4.
- Conflict: IfReq and DmReq rise together after reset. Expect DM granted first, IF second, then alternation while both stay high; no Ack is ever issued to the wrong side.
- Errors: half load at 0x101, word store at 0x3FE, and DmSize = 11. Each gets DmAck with DmErr = 1 one cycle after grant, no MemRead/MemWrite cycles, and DmRdData unchanged.
- Reset mid-store: drop Reset_n during the 2nd byte of a word store. Expect MemWrite = 0 immediately, Busy = 0, state IDLE, no DmAck. Only byte 0 has been committed, and byte 1 if its write edge already occurred.
- Byte store at MEM_BYTES-1: one write with MemWriteData = {24'b0, DmWrData[7:0]}, then DmAck with DmErr = 0.
